// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, instr, fault flags}
// with sticky overflow flag. Define INSTR_QUEUE_BYPASS_EN for empty-queue bypass.
module instr_queue #(
  parameter int RISCV_ARCH = 64,
  parameter int DEPTH      = 4,
  parameter int CNTW       = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush_pipeline,
  input  logic                  i_valid,
  input  logic [RISCV_ARCH-1:0] i_pc,
  input  logic [63:0]           i_instr,
  input  logic                  i_load_fault,
  input  logic                  i_page_fault_x,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [RISCV_ARCH-1:0] o_pc,
  output logic [63:0]           o_instr,
  output logic                  o_load_fault,
  output logic                  o_page_fault_x,
  input  logic                  i_ready,
  output logic [CNTW-1:0]       o_count,
  output logic                  o_overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [RISCV_ARCH-1:0] r_mem_pc    [DEPTH];
  logic [63:0]           r_mem_instr [DEPTH];
  logic                  r_mem_lf    [DEPTH];
  logic                  r_mem_pf    [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_cnt;
  logic            r_overflow;

  logic                  w_ready;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_valid;
  logic [RISCV_ARCH-1:0] w_head_pc;
  logic [63:0]           w_head_instr;
  logic                  w_head_lf;
  logic                  w_head_pf;

  assign w_empty = (r_cnt == '0);
  // Full queue refuses a push even when decode pops in the same cycle.
  assign w_ready = (r_cnt != CNTW'(DEPTH));
  assign w_pop   = !w_empty && i_ready;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_empty && i_valid && !i_flush_pipeline;
  // A bypassed word taken by decode this cycle is never stored.
  assign w_push   = i_valid && w_ready && !(w_bypass && i_ready);
`else
  assign w_push   = i_valid && w_ready;
`endif

  always_comb begin
    w_head_valid = !w_empty;
    w_head_pc    = r_mem_pc[r_rd_ptr];
    w_head_instr = r_mem_instr[r_rd_ptr];
    w_head_lf    = r_mem_lf[r_rd_ptr];
    w_head_pf    = r_mem_pf[r_rd_ptr];
`ifdef INSTR_QUEUE_BYPASS_EN
    if (w_bypass) begin
      w_head_valid = 1'b1;
      w_head_pc    = i_pc;
      w_head_instr = i_instr;
      w_head_lf    = i_load_fault;
      w_head_pf    = i_page_fault_x;
    end
`endif
  end

  always_comb begin
    o_valid        = w_head_valid;
    o_pc           = {RISCV_ARCH{1'b1}};
    o_instr        = '0;
    o_load_fault   = 1'b0;
    o_page_fault_x = 1'b0;
    if (w_head_valid) begin
      o_pc           = w_head_pc;
      o_instr        = w_head_instr;
      o_load_fault   = w_head_lf;
      o_page_fault_x = w_head_pf;
    end
  end

  assign o_ready    = w_ready;
  assign o_count    = r_cnt;
  assign o_overflow = r_overflow;

  // Storage is not reset; only entries below r_cnt are ever observable.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush_pipeline && w_push) begin
      r_mem_pc[r_wr_ptr]    <= i_pc;
      r_mem_instr[r_wr_ptr] <= i_instr;
      r_mem_lf[r_wr_ptr]    <= i_load_fault;
      r_mem_pf[r_wr_ptr]    <= i_page_fault_x;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid && !w_ready) begin
        r_overflow <= 1'b1;
      end
      if (i_flush_pipeline) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CNTW'(1);
          2'b01:   r_cnt <= r_cnt - CNTW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Randomized bench for instr_queue against a queue-based reference model,
// preceded by directed fill/drain, overflow, wrap, flush and fault sequences.
module tb_instr_queue;

  localparam int RA    = 64;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  typedef struct {
    logic [63:0] pc;
    logic [63:0] instr;
    logic        lf;
    logic        pf;
  } ent_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_flush_pipeline = 1'b0;
  logic            i_valid = 1'b0;
  logic [RA-1:0]   i_pc = '0;
  logic [63:0]     i_instr = '0;
  logic            i_load_fault = 1'b0;
  logic            i_page_fault_x = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_ready, o_valid, o_load_fault, o_page_fault_x, o_overflow;
  logic [RA-1:0]   o_pc;
  logic [63:0]     o_instr;
  logic [CNTW-1:0] o_count;

  instr_queue #(.RISCV_ARCH(RA), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush_pipeline(i_flush_pipeline),
    .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
    .i_load_fault(i_load_fault), .i_page_fault_x(i_page_fault_x),
    .o_ready(o_ready), .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
    .o_load_fault(o_load_fault), .o_page_fault_x(o_page_fault_x),
    .i_ready(i_ready), .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int   n_total = 0;
  int   n_bad   = 0;
  int   n_deliv = 0;
  ent_t mdl_q[$];
  bit   mdl_ovf = 1'b0;

  logic        s_valid, s_ready, s_ovf, s_lf, s_pf;
  logic [63:0] s_pc, s_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit   ev, er, pop, push, byp;
    ent_t hd;
    @(negedge i_clk);
    er  = (mdl_q.size() != DEPTH);
    ev  = (mdl_q.size() != 0);
    byp = 1'b0;
    hd  = '{pc: '1, instr: '0, lf: 1'b0, pf: 1'b0};
    if (ev) hd = mdl_q[0];
`ifdef INSTR_QUEUE_BYPASS_EN
    if (mdl_q.size() == 0 && i_valid && !i_flush_pipeline) begin
      ev  = 1'b1;
      byp = 1'b1;
      hd  = '{pc: i_pc, instr: i_instr, lf: i_load_fault, pf: i_page_fault_x};
    end
`endif
    s_valid = o_valid; s_ready = o_ready; s_ovf = o_overflow;
    s_pc = o_pc; s_lf = o_load_fault; s_pf = o_page_fault_x;
    s_count = 64'(o_count);
    check("valid", 64'(o_valid), 64'(ev));
    check("ready", 64'(o_ready), 64'(er));
    check("count", 64'(o_count), 64'(mdl_q.size()));
    check("ovf",   64'(o_overflow), 64'(mdl_ovf));
    check("pc",    o_pc, hd.pc);
    check("instr", o_instr, hd.instr);
    check("lf",    64'(o_load_fault), 64'(hd.lf));
    check("pf",    64'(o_page_fault_x), 64'(hd.pf));
    if (ev && i_ready && !i_rst && !i_flush_pipeline) n_deliv++;
    @(posedge i_clk);
    if (i_rst) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      if (i_valid && !er) mdl_ovf = 1'b1;
      if (i_flush_pipeline) begin
        mdl_q.delete();
      end else if (!(byp && i_ready)) begin
        pop  = ev && i_ready && !byp;
        push = i_valid && er;
        if (pop) void'(mdl_q.pop_front());
        if (push) mdl_q.push_back('{pc: i_pc, instr: i_instr, lf: i_load_fault, pf: i_page_fault_x});
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [63:0] pc, input bit rdy);
    i_valid = v;
    i_pc    = pc;
    i_instr = {$urandom, $urandom};
    i_load_fault   = 1'b0;
    i_page_fault_x = 1'b0;
    i_ready = rdy;
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    cycle();
    cycle();
    check("rst_pc",    s_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_count", s_count, 64'd0);
    i_rst = 1'b0;
    cycle();

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(8 * i), 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0);
    cycle();
    check("fill_count", s_count, 64'd4);
    check("fill_ready", 64'(s_ready), 64'd0);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("drain_pc", s_pc, 64'h1000 + 64'(8 * i));
    end
    cycle();
    check("drain_count", s_count, 64'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(8 * i), 1'b0);
      cycle();
    end
    drive(1'b1, 64'h2000, 1'b1);
    cycle();
    check("ovf_pop_pc", s_pc, 64'h1000);
    drive(1'b0, '0, 1'b0);
    cycle();
    check("ovf_count", s_count, 64'd3);
    check("ovf_set",   64'(s_ovf), 64'd1);
    i_flush_pipeline = 1'b1;
    cycle();
    i_flush_pipeline = 1'b0;
    cycle();
    check("ovf_after_flush", 64'(s_ovf), 64'd1);

    n_deliv = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h5000 + 64'(8 * i), 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    cycle();
    cycle();
    check("wrap_delivered", 64'(n_deliv), 64'd10);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h2100 + 64'(8 * i), 1'b0);
      cycle();
    end
    drive(1'b1, 64'h3000, 1'b0);
    i_flush_pipeline = 1'b1;
    cycle();
    i_flush_pipeline = 1'b0;
    drive(1'b0, '0, 1'b1);
    cycle();
    check("flush_valid", 64'(s_valid), 64'd0);
    check("flush_count", s_count, 64'd0);

    drive(1'b1, 64'h4000, 1'b0);
    i_page_fault_x = 1'b1;
    cycle();
    drive(1'b0, '0, 1'b0);
    cycle();
    check("fault_pc", s_pc, 64'h4000);
    check("fault_pf", 64'(s_pf), 64'd1);
    i_ready = 1'b1;
    cycle();
    cycle();
`ifdef INSTR_QUEUE_BYPASS_EN
    drive(1'b1, 64'h4100, 1'b1);
    cycle();
    check("byp_valid", 64'(s_valid), 64'd1);
    check("byp_pc",    s_pc, 64'h4100);
    drive(1'b0, '0, 1'b0);
    cycle();
    check("byp_count", s_count, 64'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(99) < 60, {32'h0, $urandom} & 64'hFFFF_FFF8, $urandom_range(99) < 55);
      i_load_fault     = $urandom_range(7) == 0;
      i_page_fault_x   = $urandom_range(7) == 0;
      i_flush_pipeline = $urandom_range(39) == 0;
      i_rst            = $urandom_range(299) == 0;
      cycle();
    end
    i_rst = 1'b0;
    i_flush_pipeline = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", n_total);
    $fatal(1, "timeout");
  end

endmodule
